fpadd_seq_control: RTL and testbench
====================================

# fpadd_seq_control

Parametrised sequencing controller for the floating-point adder datapath. Successor to the single-format adder control FSM: generic exponent/mantissa widths, a ready/valid handshake on both sides, multi-cycle alignment through a bounded right shifter, four IEEE rounding modes, a zero-result path and post-round renormalisation. It drives the datapath's mux selects, shifter enables/amounts and exponent adjust strobes. It holds no mantissa data itself.

## Interface
- EXPBITS, 8, exponent width
- MANTISSABITS, 23, stored mantissa width; hidden-bit position H = MANTISSABITS
- MAXSHIFT, 8, maximum right-shift distance per alignment cycle
- Derived: IDXBITS = $clog2(MANTISSABITS+2); SHBITS = $clog2(MANTISSABITS+4)

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low
- InValid  in  1  new operation request
- InReady  out  1  controller idle, can accept
- ExpSet  in  1  1 = operand A exponent ≥ B exponent; captured on accept
- ExpDiff  in  EXPBITS  exponent difference magnitude; captured on accept
- RoundMode  in  2  00 RNE, 01 RTZ, 10 toward +inf, 11 toward −inf; captured on accept
- Sign  in  1  result sign, sampled in ROUND
- FFOValid  in  1  first-one finder found a set bit; sampled in NORM
- FFOIndex  in  IDXBITS  first-one position in sum; sampled in NORM
- Out  in  MANTISSABITS+2  datapath sum; [0] = LSB, [MANTISSABITS+1] = carry
- GRS  in  3  guard, round, sticky bits
- OutValid  out  1  result complete
- OutReady  in  1  consumer accepts result
- SelExpMux  out  1  registered ExpSet; selects the larger exponent
- SelSRMux  out  1  0 = right shifter on smaller operand (align), 1 = on sum (normalise)
- SREn  out  1  right-shift strobe
- ShiftRightAmount  out  SHBITS  right-shift distance
- AddEn  out  1  adder result load
- SLEn  out  1  left-shift strobe
- ShiftAmount  out  SHBITS  left-shift distance
- NoShift  out  1  sum already normalised
- IncrEn  out  1  exponent +1
- DecrEn  out  1  exponent −ShiftAmount
- RoundEn  out  1  add 1 ulp to the mantissa
- SelExpMuxR, SelManMuxR  out  1 each  select post-round exponent/mantissa (1 in RENORM and later)
- Zero  out  1  result is exact zero

## Operation
- States: IDLE, ALIGN, ADD, NORM, ROUND, RENORM, DONE. Outputs are Moore, decoded from the state and internal registers.
- IDLE: InReady=1. On InValid&InReady, capture ExpSet, RoundMode and Rem = min(ExpDiff, MANTISSABITS+3). Next state is ALIGN if Rem≠0, else ADD.
- ALIGN: SREn=1, SelSRMux=0, ShiftRightAmount = min(Rem, MAXSHIFT), and Rem decreases by that amount. Exit to ADD when Rem reaches 0 after the shift.
- ADD: AddEn=1 for one cycle, then NORM.
- NORM: behaviour depends on the sampled FFO inputs.
  - FFOValid=0: Zero=1 (held until IDLE), go to DONE.
  - FFOIndex=H+1: SREn=1, SelSRMux=1, amount 1, IncrEn=1.
  - FFOIndex=H: NoShift=1.
  - FFOIndex<H: SLEn=1, DecrEn=1, ShiftAmount = H−FFOIndex.
  - For every FFOValid=1 case, the next state is ROUND.
- ROUND: round-up decision from G, R, S, L=Out[0] and mode:
  - RNE: G&(R|S|L)
  - RTZ: 0
  - +inf: ~Sign&(G|R|S)
  - −inf: Sign&(G|R|S)
  - Decision=1: RoundEn=1, next RENORM. Decision=0: next DONE.
- RENORM: if Out[MANTISSABITS+1]=1, SREn=1, SelSRMux=1, amount 1, IncrEn=1. At most one renormalisation. Next DONE.
- DONE: OutValid=1 held until OutReady=1, then IDLE. InValid is ignored outside IDLE.
- Exponent overflow/underflow is the datapath's responsibility.

## Timing
- Reset (async, any state) forces IDLE, clears all registers, InReady=1 and every other output 0. After Reset deasserts, the first accept can happen on the next edge.
- Latency, counting the accept edge as cycle 0: ALIGN takes ceil(Rem/MAXSHIFT) cycles, then ADD, NORM, ROUND (+1 for RENORM if rounded), then DONE.
- ExpDiff=0 with no round-up: OutValid in cycle 4.
- Zero result: ROUND is skipped, so OutValid in cycle 3.
- Back-to-back operation: OutReady=1 in DONE returns to IDLE, so the next accept is at the earliest one cycle later.
- ExpDiff ≥ MANTISSABITS+3 clamps Rem; all shifted-out bits become sticky in the datapath.

## Structure
- Package fpadd_pkg holds the state enum, the RoundMode enum and the IDXBITS/SHBITS width helpers.
- Sub-module fpadd_round_decide: combinational round-up decision (G, R, S, L, Sign, RoundMode → RoundUp).

## Test plan
- Default params. ExpSet=1, ExpDiff=8'h55 → Rem=26; ALIGN amounts 8,8,8,2; SelExpMux=1; ADD in cycle 5.
- ExpDiff=0, FFOIndex=24, RNE, GRS=100, Out[0]=1 → NORM SREn/IncrEn; RoundEn; RENORM with Out[24]=1 → SREn amount 1, IncrEn; OutValid in cycle 5.
- FFOValid=0 → Zero=1, no RoundEn, OutValid in cycle 3.
- FFOIndex=20, RTZ, GRS=111 → SLEn, ShiftAmount=3, DecrEn; no RoundEn.
- +inf mode, Sign=1, GRS=001 → no round. −inf mode, Sign=1, GRS=001 → RoundEn=1.
- OutReady low for 3 cycles in DONE with InValid=1 → OutValid held, InReady=0, no accept. Reset pulsed mid-ALIGN → immediate IDLE with all outputs at reset values.

Source files
------------

// File: rtl/fpadd_seq_control_pkg.sv
// fpadd_pkg: shared types and width helpers for the FP adder sequencer.
// Holds the controller state enum, rounding-mode enum and derived widths.
package fpadd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_RENORM,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_POS = 2'b10,
        RM_NEG = 2'b11
    } rmode_e;

    // first-one index range: 0 .. MANTISSABITS+1
    function automatic int idxbits(input int m);
        return $clog2(m + 2);
    endfunction

    // shift distance range: 0 .. MANTISSABITS+3
    function automatic int shbits(input int m);
        return $clog2(m + 4);
    endfunction

endpackage

// File: rtl/fpadd_seq_control_if.sv
// fpadd_seq_control_if: request/response handshake plus datapath controls.
// master = sequencing controller, slave = datapath and requester side.
interface fpadd_seq_control_if #(
    parameter int EXPBITS      = 8,
    parameter int MANTISSABITS = 23
);
    import fpadd_pkg::*;

    localparam int IDXBITS = idxbits(MANTISSABITS);
    localparam int SHBITS  = shbits(MANTISSABITS);

    logic                    InValid;
    logic                    InReady;
    logic                    ExpSet;
    logic [EXPBITS-1:0]      ExpDiff;
    logic [1:0]              RoundMode;
    logic                    Sign;
    logic                    FFOValid;
    logic [IDXBITS-1:0]      FFOIndex;
    logic [MANTISSABITS+1:0] Out;
    logic [2:0]              GRS;
    logic                    OutValid;
    logic                    OutReady;
    logic                    SelExpMux;
    logic                    SelSRMux;
    logic                    SREn;
    logic [SHBITS-1:0]       ShiftRightAmount;
    logic                    AddEn;
    logic                    SLEn;
    logic [SHBITS-1:0]       ShiftAmount;
    logic                    NoShift;
    logic                    IncrEn;
    logic                    DecrEn;
    logic                    RoundEn;
    logic                    SelExpMuxR;
    logic                    SelManMuxR;
    logic                    Zero;

    modport master (
        input  InValid, ExpSet, ExpDiff, RoundMode, Sign,
        input  FFOValid, FFOIndex, Out, GRS, OutReady,
        output InReady, OutValid, SelExpMux, SelSRMux, SREn,
        output ShiftRightAmount, AddEn, SLEn, ShiftAmount,
        output NoShift, IncrEn, DecrEn, RoundEn,
        output SelExpMuxR, SelManMuxR, Zero
    );

    modport slave (
        output InValid, ExpSet, ExpDiff, RoundMode, Sign,
        output FFOValid, FFOIndex, Out, GRS, OutReady,
        input  InReady, OutValid, SelExpMux, SelSRMux, SREn,
        input  ShiftRightAmount, AddEn, SLEn, ShiftAmount,
        input  NoShift, IncrEn, DecrEn, RoundEn,
        input  SelExpMuxR, SelManMuxR, Zero
    );

endinterface

// File: rtl/fpadd_seq_control_round_decide.sv
// fpadd_round_decide: combinational round-up decision.
// In: g, r, s, l (result LSB), sign, mode. Out: round_up.
module fpadd_round_decide
    import fpadd_pkg::*;
(
    input  logic   g,
    input  logic   r,
    input  logic   s,
    input  logic   l,
    input  logic   sign,
    input  rmode_e mode,
    output logic   round_up
);

    always_comb begin
        round_up = 1'b0;
        unique case (mode)
            RM_RNE:  round_up = g & (r | s | l);
            RM_RTZ:  round_up = 1'b0;
            RM_POS:  round_up = ~sign & (g | r | s);
            RM_NEG:  round_up = sign & (g | r | s);
            default: round_up = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpadd_seq_control.sv
// fpadd_seq_control: FP adder sequencer (align, add, normalise, round).
// Ports: Clock, Reset (async low), bus = fpadd_seq_control_if.master.
module fpadd_seq_control
    import fpadd_pkg::*;
#(
    parameter int EXPBITS      = 8,
    parameter int MANTISSABITS = 23,
    parameter int MAXSHIFT     = 8
) (
    input logic                 Clock,
    input logic                 Reset,
    fpadd_seq_control_if.master bus
);

    localparam int IDXBITS = idxbits(MANTISSABITS);
    localparam int SHBITS  = shbits(MANTISSABITS);
    localparam int H       = MANTISSABITS;
    localparam int REMMAX  = MANTISSABITS + 3;

    state_e            state, state_nx;
    logic [SHBITS-1:0] rem;
    logic [SHBITS-1:0] rem_init;
    logic [SHBITS-1:0] align_amt;
    logic              exp_set_q;
    rmode_e            rmode_q;
    logic              zero_q;
    logic              accept;
    logic              ffo_zero;
    logic              round_up;

    logic              in_ready, out_valid, sel_sr, sr_en;
    logic [SHBITS-1:0] sr_amt, sl_amt;
    logic              add_en, sl_en, no_shift, incr_en, decr_en;
    logic              round_en, sel_r, zero;

    // only the LSB and carry of the sum steer the sequence
    logic unused_out;
    assign unused_out = ^bus.Out[H:1];

    assign accept   = (state == S_IDLE) && bus.InValid;
    assign ffo_zero = (state == S_NORM) && !bus.FFOValid;

    // beyond MANTISSABITS+3 every shifted bit lands in sticky anyway
    always_comb begin
        if (32'(bus.ExpDiff) > 32'(REMMAX))
            rem_init = SHBITS'(REMMAX);
        else
            rem_init = SHBITS'(bus.ExpDiff);
    end

    always_comb begin
        if (32'(rem) > 32'(MAXSHIFT))
            align_amt = SHBITS'(MAXSHIFT);
        else
            align_amt = rem;
    end

    fpadd_round_decide u_round (
        .g        (bus.GRS[2]),
        .r        (bus.GRS[1]),
        .s        (bus.GRS[0]),
        .l        (bus.Out[0]),
        .sign     (bus.Sign),
        .mode     (rmode_q),
        .round_up (round_up)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:
                if (bus.InValid)
                    state_nx = (rem_init != '0) ? S_ALIGN : S_ADD;
            S_ALIGN:
                if (rem == align_amt)
                    state_nx = S_ADD;
            S_ADD:
                state_nx = S_NORM;
            S_NORM:
                state_nx = bus.FFOValid ? S_ROUND : S_DONE;
            S_ROUND:
                state_nx = round_up ? S_RENORM : S_DONE;
            S_RENORM:
                state_nx = S_DONE;
            S_DONE:
                if (bus.OutReady)
                    state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rem       <= '0;
            exp_set_q <= 1'b0;
            rmode_q   <= RM_RNE;
            zero_q    <= 1'b0;
        end else begin
            if (accept) begin
                rem       <= rem_init;
                exp_set_q <= bus.ExpSet;
                rmode_q   <= rmode_e'(bus.RoundMode);
            end else if (state == S_ALIGN) begin
                rem <= rem - align_amt;
            end
            // zero flag lives from NORM until the result is taken
            if (ffo_zero)
                zero_q <= 1'b1;
            else if (state == S_DONE && bus.OutReady)
                zero_q <= 1'b0;
        end
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        sel_r     = (state == S_RENORM) || (state == S_DONE);
        zero      = zero_q || ffo_zero;
        sel_sr    = 1'b0;
        sr_en     = 1'b0;
        sr_amt    = '0;
        add_en    = 1'b0;
        sl_en     = 1'b0;
        sl_amt    = '0;
        no_shift  = 1'b0;
        incr_en   = 1'b0;
        decr_en   = 1'b0;
        round_en  = 1'b0;
        unique case (state)
            S_ALIGN: begin
                sr_en  = 1'b1;
                sr_amt = align_amt;
            end
            S_ADD:
                add_en = 1'b1;
            S_NORM:
                if (bus.FFOValid) begin
                    unique case (1'b1)
                        (bus.FFOIndex == IDXBITS'(H + 1)): begin
                            sr_en   = 1'b1;
                            sel_sr  = 1'b1;
                            sr_amt  = SHBITS'(1);
                            incr_en = 1'b1;
                        end
                        (bus.FFOIndex == IDXBITS'(H)):
                            no_shift = 1'b1;
                        (bus.FFOIndex < IDXBITS'(H)): begin
                            sl_en   = 1'b1;
                            decr_en = 1'b1;
                            sl_amt  = SHBITS'(H) - SHBITS'(bus.FFOIndex);
                        end
                        default: ;
                    endcase
                end
            S_ROUND:
                round_en = round_up;
            S_RENORM:
                if (bus.Out[H+1]) begin
                    sr_en   = 1'b1;
                    sel_sr  = 1'b1;
                    sr_amt  = SHBITS'(1);
                    incr_en = 1'b1;
                end
            default: ;
        endcase
    end

    assign bus.InReady          = in_ready;
    assign bus.OutValid         = out_valid;
    assign bus.SelExpMux        = exp_set_q;
    assign bus.SelSRMux         = sel_sr;
    assign bus.SREn             = sr_en;
    assign bus.ShiftRightAmount = sr_amt;
    assign bus.AddEn            = add_en;
    assign bus.SLEn             = sl_en;
    assign bus.ShiftAmount      = sl_amt;
    assign bus.NoShift          = no_shift;
    assign bus.IncrEn           = incr_en;
    assign bus.DecrEn           = decr_en;
    assign bus.RoundEn          = round_en;
    assign bus.SelExpMuxR       = sel_r;
    assign bus.SelManMuxR       = sel_r;
    assign bus.Zero             = zero;

endmodule

// File: tb/tb_fpadd_seq_control.sv
// tb_fpadd_seq_control: directed + random ops against a cycle trace model.
// Default parameters: EXPBITS=8, MANTISSABITS=23, MAXSHIFT=8.
module tb_fpadd_seq_control;

    localparam int M    = 23;
    localparam int MAXS = 8;

    typedef struct packed {
        logic       in_ready;
        logic       out_valid;
        logic       sel_exp;
        logic       sel_sr;
        logic       sr_en;
        logic [4:0] sr_amt;
        logic       add_en;
        logic       sl_en;
        logic [4:0] sl_amt;
        logic       no_shift;
        logic       incr;
        logic       decr;
        logic       round_en;
        logic       sel_exp_r;
        logic       sel_man_r;
        logic       zero;
    } snap_t;

    typedef struct {
        bit          expset;
        int          expdiff;
        bit [1:0]    rm;
        bit          sign;
        bit          ffov;
        int          idx;
        bit [M+1:0]  out;
        bit [2:0]    grs;
    } op_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    snap_t expq[$];

    fpadd_seq_control_if #(.EXPBITS(8), .MANTISSABITS(M)) bus ();

    fpadd_seq_control #(
        .EXPBITS(8), .MANTISSABITS(M), .MAXSHIFT(MAXS)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    function automatic snap_t observe();
        snap_t s;
        s.in_ready  = bus.InReady;
        s.out_valid = bus.OutValid;
        s.sel_exp   = bus.SelExpMux;
        s.sel_sr    = bus.SelSRMux;
        s.sr_en     = bus.SREn;
        s.sr_amt    = bus.ShiftRightAmount;
        s.add_en    = bus.AddEn;
        s.sl_en     = bus.SLEn;
        s.sl_amt    = bus.ShiftAmount;
        s.no_shift  = bus.NoShift;
        s.incr      = bus.IncrEn;
        s.decr      = bus.DecrEn;
        s.round_en  = bus.RoundEn;
        s.sel_exp_r = bus.SelExpMuxR;
        s.sel_man_r = bus.SelManMuxR;
        s.zero      = bus.Zero;
        return s;
    endfunction

    function automatic snap_t idle_snap(input bit se);
        snap_t s = '0;
        s.in_ready = 1'b1;
        s.sel_exp  = se;
        return s;
    endfunction

    task automatic check(input string tag, input snap_t exp_s);
        snap_t got = observe();
        checks++;
        assert (got === exp_s) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp_s);
        end
    endtask

    // Expected per-cycle outputs from the cycle after the accept edge
    // through DONE (held hold+1 cycles) and back to IDLE.
    function automatic void build(input op_t op, input int hold);
        snap_t b, s;
        int    rem, a;
        bit    g, r, st, l, ru;
        expq.delete();
        b = '0;
        b.sel_exp = op.expset;
        rem = (op.expdiff > M + 3) ? M + 3 : op.expdiff;
        while (rem > 0) begin
            a = (rem > MAXS) ? MAXS : rem;
            s = b; s.sr_en = 1; s.sr_amt = 5'(a);
            expq.push_back(s);
            rem -= a;
        end
        s = b; s.add_en = 1;
        expq.push_back(s);
        s = b;
        if (!op.ffov) begin
            s.zero = 1;
            expq.push_back(s);
        end else begin
            if (op.idx == M + 1) begin
                s.sr_en = 1; s.sel_sr = 1; s.sr_amt = 5'd1; s.incr = 1;
            end else if (op.idx == M) begin
                s.no_shift = 1;
            end else begin
                s.sl_en = 1; s.decr = 1; s.sl_amt = 5'(M - op.idx);
            end
            expq.push_back(s);
            g = op.grs[2]; r = op.grs[1]; st = op.grs[0]; l = op.out[0];
            case (op.rm)
                2'd0: ru = g && (r || st || l);
                2'd1: ru = 0;
                2'd2: ru = !op.sign && (g || r || st);
                default: ru = op.sign && (g || r || st);
            endcase
            s = b; s.round_en = ru;
            expq.push_back(s);
            if (ru) begin
                s = b; s.sel_exp_r = 1; s.sel_man_r = 1;
                if (op.out[M+1]) begin
                    s.sr_en = 1; s.sel_sr = 1; s.sr_amt = 5'd1; s.incr = 1;
                end
                expq.push_back(s);
            end
        end
        s = b; s.out_valid = 1; s.sel_exp_r = 1; s.sel_man_r = 1;
        s.zero = !op.ffov;
        for (int i = 0; i <= hold; i++) expq.push_back(s);
        expq.push_back(idle_snap(op.expset));
    endfunction

    // Called #1 after an edge with the controller idle.
    task automatic run_op(input string name, input op_t op, input int hold);
        build(op, hold);
        bus.ExpSet    = op.expset;
        bus.ExpDiff   = 8'(op.expdiff);
        bus.RoundMode = op.rm;
        bus.Sign      = op.sign;
        bus.FFOValid  = op.ffov;
        bus.FFOIndex  = 5'(op.idx);
        bus.Out       = op.out;
        bus.GRS       = op.grs;
        bus.OutReady  = 1'($urandom % 2);
        bus.InValid   = 1'b1;
        @(posedge Clock); #1;
        // captured fields must no longer matter
        bus.ExpSet    = 1'($urandom);
        bus.ExpDiff   = 8'($urandom);
        bus.RoundMode = 2'($urandom);
        for (int i = 0; i < expq.size(); i++) begin
            check($sformatf("%s c%0d", name, i + 1), expq[i]);
            if (i == expq.size() - 1) break;
            bus.InValid = 1'($urandom % 2);
            if (expq[i].out_valid)
                bus.OutReady = (i == expq.size() - 2);
            else
                bus.OutReady = 1'($urandom % 2);
            @(posedge Clock); #1;
        end
        bus.InValid = 1'b0;
    endtask

    function automatic op_t mk(input bit se, input int ed, input bit [1:0] rm,
                               input bit sg, input bit fv, input int idx,
                               input bit [M+1:0] o, input bit [2:0] grs);
        op_t op;
        op.expset = se; op.expdiff = ed; op.rm = rm; op.sign = sg;
        op.ffov = fv; op.idx = idx; op.out = o; op.grs = grs;
        return op;
    endfunction

    initial begin
        op_t   op;
        snap_t s;
        bus.InValid = 0; bus.ExpSet = 0; bus.ExpDiff = 0; bus.RoundMode = 0;
        bus.Sign = 0; bus.FFOValid = 0; bus.FFOIndex = 0; bus.Out = 0;
        bus.GRS = 0; bus.OutReady = 0;
        #1;
        check("reset_async", idle_snap(1'b0));
        @(posedge Clock); #1;
        check("reset_held", idle_snap(1'b0));
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock); #1;
        check("after_reset", idle_snap(1'b0));

        // long clamped alignment: 8,8,8,2 then ADD in cycle 5
        run_op("align55", mk(1, 'h55, 2'd0, 0, 1, M, '0, 3'b000), 0);
        // round up plus renormalisation: OutValid in cycle 5
        op = mk(0, 0, 2'd0, 0, 1, M + 1, '0, 3'b100);
        op.out[0] = 1; op.out[M+1] = 1;
        run_op("renorm", op, 0);
        run_op("zero", mk(0, 0, 2'd0, 1, 0, 0, '1, 3'b111), 0);
        run_op("rtz_left", mk(1, 3, 2'd1, 0, 1, 20, '1, 3'b111), 0);
        run_op("pinf_neg", mk(0, 0, 2'd2, 1, 1, M, '0, 3'b001), 0);
        run_op("ninf_neg", mk(0, 0, 2'd3, 1, 1, M, '0, 3'b001), 0);
        // consumer stalls 3 cycles while a new request waits
        run_op("stall", mk(1, 9, 2'd0, 0, 1, M, '0, 3'b000), 3);
        run_op("exact26", mk(0, M + 3, 2'd0, 0, 1, 0, '0, 3'b110), 1);

        // reset pulsed mid-alignment
        bus.ExpSet = 1; bus.ExpDiff = 8'd40; bus.InValid = 1;
        @(posedge Clock); #1;
        bus.InValid = 0;
        s = '0; s.sel_exp = 1; s.sr_en = 1; s.sr_amt = 5'd8;
        check("pre_rst_align", s);
        @(posedge Clock); #2;
        Reset = 1'b0;
        #1;
        check("mid_align_rst", idle_snap(1'b0));
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock); #1;
        check("post_rst_idle", idle_snap(1'b0));

        for (int n = 0; n < 40; n++) begin
            op.expset  = 1'($urandom);
            op.expdiff = ($urandom % 6 == 0) ? int'($urandom_range(27, 255))
                                             : int'($urandom_range(0, 30));
            op.rm      = 2'($urandom);
            op.sign    = 1'($urandom);
            op.ffov    = ($urandom % 8) != 0;
            op.idx     = $urandom_range(0, M + 1);
            op.out     = (M + 2)'($urandom);
            op.grs     = 3'($urandom);
            run_op($sformatf("rnd%0d", n), op, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
